fpu_add_wb: RTL and testbench
=============================

FPU_ADD_WB -- requirements
Module: fpu_add_wb

Interface
REQ-001 Parameter LAT, default 2: cycles from an accepted issue to its result on fpu_res; range 1..4.
REQ-002 Parameter DEPTH, default 4: result FIFO entries; power of two, 2..16.
REQ-003 Parameter TAGW, default 6: tag width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 issue_vld  input  1  operation issued to adder this cycle.
REQ-007 issue_tag  input  TAGW  destination tag of issued op.
REQ-008 issue_rdy  output  1  credit available; issue accepted only when issue_vld&&issue_rdy.
REQ-009 fpu_res  input  64  adder result; sign[63], exp[62:53] bias 0x200, mantissa[52:0].
REQ-010 wb_vld  output  1  FIFO head valid.
REQ-011 wb_rdy  input  1  consumer accepts head.
REQ-012 wb_tag  output  TAGW  head tag.
REQ-013 wb_data  output  64  head result after post-processing.
REQ-014 wb_exc  output  2  head flags: [0] zero, [1] exponent saturated (0x3FF).

Function
REQ-015 Tag pipeline: LAT-stage shift register of {valid,tag}; accepted issue enters stage 0; stage LAT-1 output is the capture strobe.
REQ-016 On capture strobe, fpu_res sampled in that same cycle, post-processed, pushed with tag into FIFO.
REQ-017 Post-process: exp==0 -> data={sign,10'h0,53'h0}, exc[0]=1; exp==0x3FF -> mantissa forced to 0, exc[1]=1; else data unchanged, exc=0.
REQ-018 Credit rule: issue_rdy = (inflight + occupancy) < DEPTH, inflight = valid stages in tag pipeline; computed from registered state only, no combinational path from wb_rdy.
REQ-019 Credit rule guarantees a push never hits a full FIFO; push while full is a design error, flagged by assertion, data dropped, state unchanged.
REQ-020 Pop on wb_vld&&wb_rdy; head advances next cycle.
REQ-021 Simultaneous push and pop: occupancy unchanged; pushed entry kept; pop of the only entry with push leaves the new entry as head.
REQ-022 Push into empty FIFO: wb_vld rises the cycle after capture (one-cycle FIFO latency, no bypass).
REQ-023 Read/write pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
REQ-024 Ordering: results delivered strictly in issue order.
REQ-025 wb_tag/wb_data/wb_exc held stable while wb_vld&&!wb_rdy.
REQ-026 fpu_res ignored in cycles without capture strobe.
REQ-027 Throughput: one issue and one writeback per cycle sustained when wb_rdy held high.

Reset
REQ-028 rst low asynchronously clears tag-pipeline valids, pointers, occupancy; wb_vld=0, issue_rdy=0 while rst low.
REQ-029 wb_tag, wb_data, wb_exc reset to 0.
REQ-030 Reset mid-operation discards all in-flight and queued results; no writeback of pre-reset ops after release.
REQ-031 issue_rdy=1 in first cycle after rst deasserts (synchronously released).

Verification
REQ-032 Single issue tag=5, fpu_res=0x4010_0000_0000_0001 at cycle LAT -> wb_vld at issue+LAT+1, wb_tag=5, wb_data equal, wb_exc=0.
REQ-033 wb_rdy=0, issue every cycle -> exactly DEPTH accepted, issue_rdy=0 thereafter; raise wb_rdy -> tags in order 0..DEPTH-1, no loss.
REQ-034 fpu_res exp=0x000 mantissa 0x1234, sign 1 -> wb_data=0x8000_0000_0000_0000, wb_exc=01; exp=0x3FF -> mantissa 0, wb_exc=10.
REQ-035 FIFO holding one entry, pop and capture same cycle -> occupancy stays 1, head becomes new tag.
REQ-036 rst pulsed low with 2 in flight and 3 queued -> wb_vld=0 immediately, no stale writeback for 20 cycles after release, issue_rdy=1.
REQ-037 Random issue/wb_rdy 10k cycles, scoreboard -> in-order, no drop/duplicate, push-when-full assertion never fires.

Source files
------------

// File: rtl/fpu_add_wb.sv
// FP adder writeback stage: tag pipeline alongside the adder, result post-processing
// and a credit-managed in-order result FIFO feeding the register-file write port.

module fpu_add_wb_chk (
  input logic clk,
  input logic rst,
  input logic cap,
  input logic full
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(cap && full));
endmodule

module fpu_add_wb #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAGW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_vld,
  input  logic [TAGW-1:0] issue_tag,
  output logic            issue_rdy,
  input  logic [63:0]     fpu_res,
  output logic            wb_vld,
  input  logic            wb_rdy,
  output logic [TAGW-1:0] wb_tag,
  output logic [63:0]     wb_data,
  output logic [1:0]      wb_exc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 4;
  localparam int EW = TAGW + 66;

  // Returns {exc[1:0], data[63:0]}; zero flushes the mantissa, saturation clears it.
  function automatic logic [65:0] post_proc(input logic [63:0] d);
    logic [65:0] r;
    case (d[62:53])
      10'h000: r = {2'b01, d[63], 63'h0};
      10'h3FF: r = {2'b10, d[63:53], 53'h0};
      default: r = {2'b00, d};
    endcase
    return r;
  endfunction

  logic [LAT-1:0]  r_pv;
  logic [TAGW-1:0] r_pt [LAT];
  logic [AW:0]     r_wp, r_rp;
  logic [EW-1:0]   r_mem [DEPTH];
  logic            r_issue_rdy, r_wb_vld;
  logic [TAGW-1:0] r_wb_tag;
  logic [63:0]     r_wb_data;
  logic [1:0]      r_wb_exc;

  logic            w_acc, w_cap, w_full, w_push, w_pop, w_rdy_nxt, w_hd_ld;
  logic [AW:0]     w_occ, w_rp_nxt, w_wp_nxt;
  logic [LAT-1:0]  w_pv_nxt;
  logic [CW-1:0]   w_infl_nxt, w_occ_nxt, w_after_pop;
  logic [EW-1:0]   w_ent, w_hd;

  assign w_acc  = issue_vld && r_issue_rdy;
  assign w_cap  = r_pv[LAT-1];
  assign w_occ  = r_wp - r_rp;
  assign w_full = (w_occ == (AW+1)'(DEPTH));
  assign w_push = w_cap && !w_full;
  assign w_pop  = r_wb_vld && wb_rdy;
  assign w_ent  = {r_pt[LAT-1], post_proc(fpu_res)};

  // Next-state view of pipeline and FIFO: credit and the entry that will be at the head.
  always_comb begin
    w_pv_nxt    = '0;
    w_infl_nxt  = '0;
    w_pv_nxt[0] = w_acc;
    for (int i = 1; i < LAT; i++) begin
      w_pv_nxt[i] = r_pv[i-1];
    end
    for (int i = 0; i < LAT; i++) begin
      w_infl_nxt = w_infl_nxt + CW'(w_pv_nxt[i]);
    end
    w_occ_nxt   = CW'(w_occ) + CW'(w_push) - CW'(w_pop);
    w_after_pop = CW'(w_occ) - CW'(w_pop);
    w_rdy_nxt   = (w_infl_nxt + w_occ_nxt) < CW'(DEPTH);
    w_rp_nxt    = r_rp + (AW+1)'(w_pop);
    w_wp_nxt    = r_wp + (AW+1)'(w_push);
    w_hd_ld     = (w_occ_nxt != '0);
    if (w_push && (w_after_pop == '0)) begin
      w_hd = w_ent;
    end else begin
      w_hd = r_mem[w_rp_nxt[AW-1:0]];
    end
  end

  // Tag pipeline: valid/tag shift register running in step with the adder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pv <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_pt[i] <= '0;
      end
    end else begin
      r_pv    <= w_pv_nxt;
      r_pt[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) begin
        r_pt[i] <= r_pt[i-1];
      end
    end
  end

  // FIFO pointers, credit and registered head outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_issue_rdy <= 1'b0;
      r_wb_vld    <= 1'b0;
      r_wb_tag    <= '0;
      r_wb_data   <= 64'h0;
      r_wb_exc    <= 2'b00;
    end else begin
      r_wp        <= w_wp_nxt;
      r_rp        <= w_rp_nxt;
      r_issue_rdy <= w_rdy_nxt;
      r_wb_vld    <= w_hd_ld;
      if (w_hd_ld) begin
        {r_wb_tag, r_wb_exc, r_wb_data} <= w_hd;
      end
    end
  end

  // Result storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp[AW-1:0]] <= w_ent;
    end
  end

  assign issue_rdy = r_issue_rdy;
  assign wb_vld    = r_wb_vld;
  assign wb_tag    = r_wb_tag;
  assign wb_data   = r_wb_data;
  assign wb_exc    = r_wb_exc;

  fpu_add_wb_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .cap  (w_cap),
    .full (w_full)
  );
endmodule

// File: tb/tb_fpu_add_wb.sv
// Bench for fpu_add_wb: queue-based behavioural model checked every cycle, plus
// directed literal checks on latency, post-processing, credit, ordering and reset.

module tb_fpu_add_wb;
  localparam int LAT   = 2;
  localparam int DEPTH = 8;
  localparam int TAGW  = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_vld, wb_rdy, issue_rdy, wb_vld;
  logic [TAGW-1:0] issue_tag, wb_tag;
  logic [63:0]     fpu_res, wb_data;
  logic [1:0]      wb_exc;

  fpu_add_wb #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .issue_vld(issue_vld), .issue_tag(issue_tag),
    .issue_rdy(issue_rdy), .fpu_res(fpu_res), .wb_vld(wb_vld), .wb_rdy(wb_rdy),
    .wb_tag(wb_tag), .wb_data(wb_data), .wb_exc(wb_exc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [TAGW-1:0] tag; int cap; } fl_t;
  typedef struct { logic [TAGW-1:0] tag; logic [63:0] data; logic [1:0] exc; } wb_t;

  fl_t   inflight[$];
  wb_t   wbq[$];
  int    cyc = 0;
  int    n_tests = 0, n_fail = 0, dut_pops = 0;
  bit    chk_en = 1'b0;
  logic [63:0] sched [32];
  bit          sched_v [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [65:0] model_post(input logic [63:0] d);
    logic [63:0] mant_mask;
    int e;
    mant_mask = (64'd1 << 53) - 64'd1;
    e = int'((d >> 53) & 64'd1023);
    if (e == 0) return {2'b01, d & 64'h8000_0000_0000_0000};
    else if (e == 1023) return {2'b10, d & ~mant_mask};
    else return {2'b00, d};
  endfunction

  // Model: issue accepted in cycle k is captured in cycle k+LAT and visible from k+LAT+1.
  always @(negedge clk) begin
    if (chk_en && rst) begin
      bit exp_rdy, exp_v;
      fl_t f;
      wb_t w;
      exp_rdy = (inflight.size() + wbq.size()) < DEPTH;
      exp_v   = wbq.size() != 0;
      chk("issue_rdy", issue_rdy, exp_rdy);
      chk("wb_vld", wb_vld, exp_v);
      if (exp_v) begin
        chk("wb_tag", wb_tag, wbq[0].tag);
        chk("wb_data", wb_data, wbq[0].data);
        chk("wb_exc", wb_exc, wbq[0].exc);
      end
      if (wb_vld && wb_rdy) dut_pops++;
      if (exp_v && wb_rdy) void'(wbq.pop_front());
      if (inflight.size() > 0 && inflight[0].cap == cyc) begin
        f = inflight.pop_front();
        w.tag = f.tag;
        {w.exc, w.data} = model_post(fpu_res);
        wbq.push_back(w);
      end
      if (issue_vld && exp_rdy) begin
        f.tag = issue_tag;
        f.cap = cyc + LAT;
        inflight.push_back(f);
      end
    end
  end

  // One cycle of stimulus; fpu_res carries the scheduled result only on capture cycles.
  task automatic drive(input logic v, input logic [TAGW-1:0] t, input logic [63:0] res,
                       input logic r, output bit acc);
    @(posedge clk); #1;
    issue_vld = v;
    issue_tag = t;
    wb_rdy    = r;
    acc = v && issue_rdy;
    if (acc) begin
      sched[(cyc + LAT) % 32]   = res;
      sched_v[(cyc + LAT) % 32] = 1'b1;
    end
    if (sched_v[cyc % 32]) fpu_res = sched[cyc % 32];
    else fpu_res = {$urandom, $urandom};
    sched_v[cyc % 32] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst = 1'b0;
    issue_vld = 1'b0;
    wb_rdy = 1'b0;
    for (int i = 0; i < 32; i++) sched_v[i] = 1'b0;
    #1;
    chk("rst_wb_vld", wb_vld, 1'b0);
    chk("rst_issue_rdy", issue_rdy, 1'b0);
    chk("rst_wb_tag", wb_tag, '0);
    chk("rst_wb_data", wb_data, 64'h0);
    chk("rst_wb_exc", wb_exc, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    inflight.delete();
    wbq.delete();
    @(posedge clk); #1;
    chk("rdy_after_rst", issue_rdy, 1'b1);
    chk_en = 1'b1;
  endtask

  task automatic single(input logic [TAGW-1:0] t, input logic [63:0] res,
                        input logic [63:0] exp_d, input logic [1:0] exp_e);
    bit acc;
    drive(1'b1, t, res, 1'b1, acc);
    chk("single_acc", acc, 1'b1);
    for (int i = 1; i <= LAT; i++) begin
      drive(1'b0, '0, 64'h0, 1'b1, acc);
      chk("single_early", wb_vld, 1'b0);
    end
    drive(1'b0, '0, 64'h0, 1'b1, acc);
    chk("single_vld", wb_vld, 1'b1);
    chk("single_tag", wb_tag, t);
    chk("single_data", wb_data, exp_d);
    chk("single_exc", wb_exc, exp_e);
    drive(1'b0, '0, 64'h0, 1'b1, acc);
    chk("single_drained", wb_vld, 1'b0);
  endtask

  initial begin
    bit acc;
    int n_acc, n_pop, stale, p0;
    logic [63:0] r;
    rst = 1'b1;
    issue_vld = 1'b0;
    issue_tag = '0;
    wb_rdy = 1'b0;
    fpu_res = 64'h0;
    for (int i = 0; i < 32; i++) sched_v[i] = 1'b0;
    do_reset();

    single(6'd5, 64'h4010_0000_0000_0001, 64'h4010_0000_0000_0001, 2'b00);
    single(6'd7, 64'h8000_0000_0000_1234, 64'h8000_0000_0000_0000, 2'b01);
    single(6'd9, 64'h7FE0_0000_0001_ABCD, 64'h7FE0_0000_0000_0000, 2'b10);

    // Credit: stalled consumer accepts exactly DEPTH, then drains in order.
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, TAGW'(i), {$urandom, $urandom}, 1'b0, acc);
      if (acc) n_acc++;
    end
    chk("credit_count", n_acc, DEPTH);
    drive(1'b0, '0, 64'h0, 1'b0, acc);
    chk("credit_rdy_low", issue_rdy, 1'b0);
    n_pop = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, '0, 64'h0, 1'b1, acc);
      if (wb_vld) begin
        chk("order_tag", wb_tag, n_pop);
        n_pop++;
      end
    end
    chk("order_count", n_pop, DEPTH);

    // Throughput: issue every cycle with consumer always ready.
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, TAGW'(i), {$urandom, $urandom}, 1'b1, acc);
      if (acc) n_acc++;
    end
    chk("throughput", n_acc, 20);
    repeat (LAT + 2) drive(1'b0, '0, 64'h0, 1'b1, acc);

    // One entry held, pop and capture in the same cycle.
    drive(1'b1, 6'd10, 64'h3FF0_0000_0000_0000, 1'b0, acc);
    drive(1'b1, 6'd11, 64'h4000_0000_0000_0000, 1'b0, acc);
    drive(1'b0, '0, 64'h0, 1'b0, acc);
    drive(1'b0, '0, 64'h0, 1'b1, acc);
    chk("pp_head_a", wb_tag, 6'd10);
    drive(1'b0, '0, 64'h0, 1'b0, acc);
    chk("pp_vld_b", wb_vld, 1'b1);
    chk("pp_head_b", wb_tag, 6'd11);
    drive(1'b0, '0, 64'h0, 1'b1, acc);
    drive(1'b0, '0, 64'h0, 1'b1, acc);
    chk("pp_empty", wb_vld, 1'b0);

    // Reset with 2 in flight and 3 queued.
    for (int i = 0; i < 5; i++) drive(1'b1, TAGW'(20 + i), {$urandom, $urandom}, 1'b0, acc);
    do_reset();
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, 64'h0, 1'b1, acc);
      if (wb_vld) stale++;
    end
    chk("no_stale_wb", stale, 0);

    // Random traffic against the model.
    p0 = dut_pops;
    n_acc = 0;
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: r[62:53] = 10'h000;
        1: r[62:53] = 10'h3FF;
        default: ;
      endcase
      drive($urandom_range(0, 9) < 7, TAGW'($urandom), r, $urandom_range(0, 9) < 6, acc);
      if (acc) n_acc++;
    end
    repeat (DEPTH + LAT + 4) drive(1'b0, '0, 64'h0, 1'b1, acc);
    chk("random_no_loss", dut_pops - p0, n_acc);
    chk("random_drained", wb_vld, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
